pipemux_rr_lock: RTL and testbench



---
 rtl/pipemux_pkg.sv | 14 +
 rtl/pipemux_rr_lock_if.sv | 28 ++
 rtl/pipemux_skid2.sv | 61 ++++++
 rtl/pipemux_rr_lock.sv | 98 +++++++++
 tb/tb_pipemux_rr_lock.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipemux_pkg.sv
// Shared definitions for TreeMux pipemux stages: source-index sizing and phit layout helpers.
package pipemux_pkg;

   // Source-index width; a single-input mux still carries a 1-bit (always 0) source field.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Packed phit size {last, src, data} for a given data width and fan-in.
   function automatic int phit_bits(input int width, input int n);
      return 1 + src_width(n) + width;
   endfunction

endpackage

// File: rtl/pipemux_rr_lock_if.sv
// N-producer / one-consumer valid-ready bundle around a pipemux stage.
interface pipemux_rr_lock_if
   import pipemux_pkg::*;
#(
   parameter int WIDTH = 72,
   parameter int N     = 4,
   parameter int SRC_W = src_width(N)
);
   logic [WIDTH-1:0] in_data [N-1:0];
   logic [N-1:0]     in_last;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic [SRC_W-1:0] out_src;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_last, out_src, out_valid
   );

   modport slave (
      input  in_data, in_last, in_valid, out_ready,
      output in_ready, out_data, out_last, out_src, out_valid
   );
endinterface

// File: rtl/pipemux_skid2.sv
// 2-entry output buffer; 1-cycle push-to-pop latency, full rate with simultaneous push/pop.
// push_rdy comes only from the registered count, so pop_rdy never reaches push_rdy combinationally.
module pipemux_skid2 #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   output logic         push_rdy,
   output logic         pop_vld,
   output logic [W-1:0] pop_dat,
   input  logic         pop_rdy
);
   logic [1:0]   count;
   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic         push;
   logic         pop;

   assign push_rdy = (count != 2'd2);
   assign pop_vld  = (count != 2'd0);
   assign pop_dat  = head;
   assign push     = push_vld && push_rdy;
   assign pop      = pop_vld && pop_rdy;

   // Head is only overwritten when new data becomes visible, so it holds its value once drained.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  head  <= push_dat;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head <= push_dat;
               end else if (push) begin
                  tail  <= push_dat;
                  count <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head  <= tail;
                  count <= 2'd1;
               end
            end
            default: count <= 2'd0;
         endcase
      end
   end
endmodule

// File: rtl/pipemux_rr_lock.sv
// Round-robin N:1 phit mux with optional packet lock; 1-cycle latency through a 2-entry output buffer.
// in_ready depends only on registered buffer occupancy and in_valid, never on out_ready.
module pipemux_rr_lock
   import pipemux_pkg::*;
#(
   parameter int WIDTH    = 72,
   parameter int N        = 4,
   parameter int PKT_LOCK = 1
) (
   input logic               CLK,
   input logic               RST_N,
   pipemux_rr_lock_if.slave  bus
);
   localparam int SRC_W = src_width(N);

   typedef struct packed {
      logic             last;
      logic [SRC_W-1:0] src;
      logic [WIDTH-1:0] data;
   } phit_t;

   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] lock_idx;
   logic             locked;
   logic [SRC_W-1:0] grant;
   logic [SRC_W-1:0] ptr_nxt;
   logic             found;
   int               idx;
   logic             space;
   logic             accept;
   phit_t            in_phit;
   phit_t            out_phit;

   // Locked grant ignores in_valid so a stalled packet owner blocks everyone else.
   always_comb begin
      grant = ptr;
      found = 1'b0;
      idx   = 0;
      if (locked) begin
         grant = lock_idx;
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && bus.in_valid[idx]) begin
               grant = SRC_W'(idx);
               found = 1'b1;
            end
         end
      end
   end

   assign accept  = bus.in_valid[grant] && space;
   assign ptr_nxt = (grant == SRC_W'(N - 1)) ? '0 : grant + 1'b1;

   always_comb begin
      bus.in_ready        = '0;
      bus.in_ready[grant] = accept && RST_N;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr      <= '0;
         lock_idx <= '0;
         locked   <= 1'b0;
      end else if (accept) begin
         if ((PKT_LOCK != 0) && !bus.in_last[grant]) begin
            locked   <= 1'b1;
            lock_idx <= grant;
         end else begin
            locked <= 1'b0;
            ptr    <= ptr_nxt;
         end
      end
   end

   always_comb begin
      in_phit.last = bus.in_last[grant];
      in_phit.src  = grant;
      in_phit.data = bus.in_data[grant];
   end

   pipemux_skid2 #(
      .W ($bits(phit_t))
   ) u_buf (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .push_vld (bus.in_valid[grant]),
      .push_dat (in_phit),
      .push_rdy (space),
      .pop_vld  (bus.out_valid),
      .pop_dat  (out_phit),
      .pop_rdy  (bus.out_ready)
   );

   assign bus.out_data = out_phit.data;
   assign bus.out_last = out_phit.last;
   assign bus.out_src  = out_phit.src;
endmodule

// File: tb/tb_pipemux_rr_lock.sv
// Bench for pipemux_rr_lock: a locked N=4 instance and an unlocked N=3 instance against a queue model.
module tb_pipemux_rr_lock;
   logic CLK;
   logic RST_N;
   int   errors = 0;
   int   checks = 0;

   pipemux_rr_lock_if #(.WIDTH(16), .N(4)) ifa ();
   pipemux_rr_lock_if #(.WIDTH(16), .N(3)) ifb ();

   pipemux_rr_lock #(.WIDTH(16), .N(4), .PKT_LOCK(1)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ifa.slave));
   pipemux_rr_lock #(.WIDTH(16), .N(3), .PKT_LOCK(0)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ifb.slave));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Per-channel stimulus queues {gap, last, data}; channels 0..3 feed A, 4..6 feed B.
   logic [17:0] dq [8][$];
   logic [7:0]  fire;

   task automatic load(input int c, input logic gap, input logic last, input logic [15:0] data);
      dq[c].push_back({gap, last, data});
   endtask

   always @(negedge CLK) begin
      fire[3:0] = ifa.in_valid & ifa.in_ready;
      fire[6:4] = ifb.in_valid & ifb.in_ready;
      fire[7]   = 1'b0;
   end

   always @(posedge CLK) begin
      #1;
      for (int c = 0; c < 8; c++) begin
         if (!RST_N) dq[c].delete();
         else if (dq[c].size() > 0 && (fire[c] || dq[c][0][17])) void'(dq[c].pop_front());
      end
      for (int c = 0; c < 4; c++) begin
         ifa.in_valid[c] = (dq[c].size() > 0) && !dq[c][0][17];
         ifa.in_last[c]  = (dq[c].size() > 0) ? dq[c][0][16] : 1'b0;
         ifa.in_data[c]  = (dq[c].size() > 0) ? dq[c][0][15:0] : 16'h0;
      end
      for (int c = 0; c < 3; c++) begin
         ifb.in_valid[c] = (dq[c+4].size() > 0) && !dq[c+4][0][17];
         ifb.in_last[c]  = (dq[c+4].size() > 0) ? dq[c+4][0][16] : 1'b0;
         ifb.in_data[c]  = (dq[c+4].size() > 0) ? dq[c+4][0][15:0] : 16'h0;
      end
   end

   // Model: pointer, lock owner (-1 = none) and a list of at most two buffered phits per instance.
   int          mptr [2];
   int          mlock[2];
   int          mcnt [2];
   logic [15:0] qd [2][2];
   logic        ql [2][2];
   int          qs [2][2];
   logic [15:0] sh_d [2];
   logic        sh_l [2];
   int          sh_s [2];
   logic [18:0] cap_a [$];
   logic [18:0] cap_b [$];

   task automatic step(input int d, input int n, input int lk,
                       input logic [3:0] v, input logic [3:0] l, input logic [3:0][15:0] dat,
                       input logic [3:0] rdy, input logic ov, input logic [15:0] od,
                       input logic ol, input logic [1:0] os, input logic ordy);
      string p;
      int    g;
      logic  acc;
      logic  found;
      p = (d == 0) ? "A" : "B";
      if (!RST_N) begin
         mptr[d] = 0; mlock[d] = -1; mcnt[d] = 0;
         sh_d[d] = 16'h0; sh_l[d] = 1'b0; sh_s[d] = 0;
         chk({p, " reset in_ready"}, 32'(rdy), 32'h0);
         chk({p, " reset out_valid"}, 32'(ov), 32'h0);
         chk({p, " reset out_fields"}, {13'h0, ol, os, od}, 32'h0);
         return;
      end
      if (mcnt[d] > 0) begin
         sh_d[d] = qd[d][0]; sh_l[d] = ql[d][0]; sh_s[d] = qs[d][0];
      end
      g = (mlock[d] >= 0) ? mlock[d] : mptr[d];
      found = 1'b0;
      if (mlock[d] < 0) begin
         for (int k = 0; k < n; k++) begin
            if (!found && v[(mptr[d] + k) % n]) begin
               g = (mptr[d] + k) % n;
               found = 1'b1;
            end
         end
      end
      acc = v[g] && (mcnt[d] < 2);
      chk({p, " in_ready"}, 32'(rdy), acc ? (32'h1 << g) : 32'h0);
      chk({p, " out_valid"}, 32'(ov), 32'(mcnt[d] > 0));
      chk({p, " out_phit"}, {13'h0, ol, os, od}, {13'h0, sh_l[d], 2'(sh_s[d]), sh_d[d]});
      if (ov && ordy) begin
         if (d == 0) cap_a.push_back({ol, os, od});
         else        cap_b.push_back({ol, os, od});
      end
      if (mcnt[d] > 0 && ordy) begin
         qd[d][0] = qd[d][1]; ql[d][0] = ql[d][1]; qs[d][0] = qs[d][1];
         mcnt[d]--;
      end
      if (acc) begin
         qd[d][mcnt[d]] = dat[g]; ql[d][mcnt[d]] = l[g]; qs[d][mcnt[d]] = g;
         mcnt[d]++;
         if (lk != 0 && !l[g]) mlock[d] = g;
         else begin
            mlock[d] = -1;
            mptr[d]  = (g + 1) % n;
         end
      end
   endtask

   always @(negedge CLK) begin
      logic [3:0][15:0] da;
      logic [3:0][15:0] db;
      for (int i = 0; i < 4; i++) da[i] = ifa.in_data[i];
      for (int i = 0; i < 3; i++) db[i] = ifb.in_data[i];
      db[3] = 16'h0;
      step(0, 4, 1, ifa.in_valid, ifa.in_last, da, ifa.in_ready, ifa.out_valid,
           ifa.out_data, ifa.out_last, ifa.out_src, ifa.out_ready);
      step(1, 3, 0, {1'b0, ifb.in_valid}, {1'b0, ifb.in_last}, db, {1'b0, ifb.in_ready},
           ifb.out_valid, ifb.out_data, ifb.out_last, ifb.out_src, ifb.out_ready);
   end

   task automatic wait_idle(input string nm);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!ok) begin
            @(posedge CLK); #3;
            ok = 1'b1;
            for (int c = 0; c < 8; c++) if (dq[c].size() != 0) ok = 1'b0;
            if (ifa.in_valid != 0 || ifb.in_valid != 0 || ifa.out_valid || ifb.out_valid) ok = 1'b0;
         end
      end
      chk({nm, " drain timeout"}, 32'(ok), 32'h1);
   endtask

   // Compares the captured output stream of instance d against hand-computed beats.
   task automatic cmp_cap(input string nm, input int d, input int n,
                          input int es[8], input int ed[8], input int el[8]);
      int sz;
      logic [18:0] got;
      sz = (d == 0) ? cap_a.size() : cap_b.size();
      chk({nm, " beat count"}, 32'(sz), 32'(n));
      for (int i = 0; i < n; i++) begin
         got = 19'h0;
         if (i < sz) got = (d == 0) ? cap_a[i] : cap_b[i];
         chk($sformatf("%s beat %0d {last,src,data}", nm, i), 32'(got),
             32'({1'(el[i]), 2'(es[i]), 16'(ed[i])}));
      end
   endtask

   initial begin
      int es[8];
      int ed[8];
      int el[8];
      RST_N = 1'b0;
      ifa.in_valid = '0; ifa.in_last = '0; ifa.out_ready = 1'b1;
      ifb.in_valid = '0; ifb.in_last = '0; ifb.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) ifa.in_data[i] = 16'h0;
      for (int i = 0; i < 3; i++) ifb.in_data[i] = 16'h0;
      repeat (2) @(posedge CLK);
      #3 RST_N = 1'b1;

      // All four channels valid with single-phit packets.
      cap_a.delete();
      for (int c = 0; c < 4; c++) begin
         load(c, 1'b0, 1'b1, 16'(16'hC0 + c));
         load(c, 1'b0, 1'b1, 16'(16'hC4 + c));
      end
      @(negedge CLK);
      @(negedge CLK);
      chk("t1 first in_ready", 32'(ifa.in_ready), 32'h1);
      chk("t1 out_valid before accept", 32'(ifa.out_valid), 32'h0);
      @(negedge CLK);
      chk("t1 out_valid one cycle later", 32'(ifa.out_valid), 32'h1);
      chk("t1 second in_ready", 32'(ifa.in_ready), 32'h2);
      wait_idle("t1");
      es = '{0, 1, 2, 3, 0, 1, 2, 3};
      ed = '{'hC0, 'hC1, 'hC2, 'hC3, 'hC4, 'hC5, 'hC6, 'hC7};
      el = '{1, 1, 1, 1, 1, 1, 1, 1};
      cmp_cap("t1 rr", 0, 8, es, ed, el);

      // Ch1 single beat moves the pointer to 2, then ch2's 3-phit packet holds the grant.
      load(1, 1'b0, 1'b1, 16'h11);
      wait_idle("t2a");
      cap_a.delete();
      load(0, 1'b0, 1'b1, 16'h01);
      load(1, 1'b0, 1'b1, 16'h12);
      load(2, 1'b0, 1'b0, 16'h20);
      load(2, 1'b0, 1'b0, 16'h21);
      load(2, 1'b0, 1'b1, 16'h22);
      wait_idle("t2");
      es = '{2, 2, 2, 0, 1, 0, 0, 0};
      ed = '{'h20, 'h21, 'h22, 'h01, 'h12, 0, 0, 0};
      el = '{0, 0, 1, 1, 1, 0, 0, 0};
      cmp_cap("t2 lock", 0, 5, es, ed, el);

      // Backpressure: ch1 streams an incrementing payload while out_ready is low.
      cap_a.delete();
      ifa.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) load(1, 1'b0, 1'b1, 16'(16'h10 + i));
      repeat (6) @(negedge CLK);
      chk("t3 in_ready when full", 32'(ifa.in_ready), 32'h0);
      chk("t3 out_data held", 32'(ifa.out_data), 32'h10);
      @(posedge CLK); #3;
      ifa.out_ready = 1'b1;
      wait_idle("t3");
      es = '{1, 1, 1, 1, 1, 1, 1, 1};
      ed = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17};
      el = '{1, 1, 1, 1, 1, 1, 1, 1};
      cmp_cap("t3 backpressure", 0, 8, es, ed, el);

      // Locked ch0 goes invalid for 3 cycles while ch3 waits.
      cap_a.delete();
      load(0, 1'b0, 1'b0, 16'h40);
      load(0, 1'b1, 1'b0, 16'h0);
      load(0, 1'b1, 1'b0, 16'h0);
      load(0, 1'b1, 1'b0, 16'h0);
      load(0, 1'b0, 1'b0, 16'h41);
      load(0, 1'b0, 1'b1, 16'h42);
      @(posedge CLK); #3;
      load(3, 1'b0, 1'b1, 16'h30);
      @(negedge CLK);
      @(negedge CLK);
      chk("t4 in_ready during stall", 32'(ifa.in_ready), 32'h0);
      wait_idle("t4");
      es = '{0, 0, 0, 3, 0, 0, 0, 0};
      ed = '{'h40, 'h41, 'h42, 'h30, 0, 0, 0, 0};
      el = '{0, 0, 1, 1, 0, 0, 0, 0};
      cmp_cap("t4 stall", 0, 4, es, ed, el);

      // Reset mid-packet with a full buffer, then ch0 must win over ch2.
      ifa.out_ready = 1'b0;
      load(2, 1'b0, 1'b0, 16'h50);
      load(2, 1'b0, 1'b0, 16'h51);
      load(2, 1'b0, 1'b0, 16'h52);
      load(2, 1'b0, 1'b1, 16'h53);
      repeat (4) @(posedge CLK);
      #3;
      chk("t5 full before reset", {ifa.in_ready, ifa.out_valid}, 32'h1);
      RST_N = 1'b0;
      #1;
      chk("t5 async out_valid", 32'(ifa.out_valid), 32'h0);
      chk("t5 async in_ready", 32'(ifa.in_ready), 32'h0);
      @(posedge CLK); #3;
      RST_N = 1'b1;
      ifa.out_ready = 1'b1;
      cap_a.delete();
      load(0, 1'b0, 1'b1, 16'h60);
      load(2, 1'b0, 1'b1, 16'h61);
      wait_idle("t5");
      es = '{0, 2, 0, 0, 0, 0, 0, 0};
      ed = '{'h60, 'h61, 0, 0, 0, 0, 0, 0};
      el = '{1, 1, 0, 0, 0, 0, 0, 0};
      cmp_cap("t5 after reset", 0, 2, es, ed, el);

      // Unlocked N=3: multi-phit packets on ch0 and ch2 interleave beat by beat.
      cap_b.delete();
      load(4, 1'b0, 1'b0, 16'h70);
      load(4, 1'b0, 1'b0, 16'h71);
      load(4, 1'b0, 1'b1, 16'h72);
      load(6, 1'b0, 1'b0, 16'h80);
      load(6, 1'b0, 1'b1, 16'h81);
      wait_idle("t6");
      es = '{0, 2, 0, 2, 0, 0, 0, 0};
      ed = '{'h70, 'h80, 'h71, 'h81, 'h72, 0, 0, 0};
      el = '{0, 0, 0, 1, 1, 0, 0, 0};
      cmp_cap("t6 interleave", 1, 5, es, ed, el);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
